branch_resolve: RTL and testbench

- Consumer end of the ALU flag interface. Takes the Z/N/V/C flags the ALU produces for a compare (A − B, ALUControl = 3'b001) together with branch decode information.
- Resolves the RISC-V conditional branch, computes the next PC and detects mispredicts.
- Presents the outcome to fetch through a one-deep registered valid/ready stage.
- Keeps saturating branch and mispredict counters for performance debug.

---
 rtl/branch_resolve_if.sv | 38 +++
 rtl/branch_resolve.sv | 126 ++++++++++++
 tb/tb_branch_resolve.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/branch_resolve_if.sv
// Request/result bundle between the ALU/decode side and fetch for branch_resolve.
// The requester (decode plus fetch) uses master and branch_resolve uses slave.
interface branch_resolve_if #(
  parameter int XLEN = 32
);
  // request side
  logic            in_valid;
  logic            in_ready;
  logic            is_branch;
  logic [2:0]      funct3;
  logic            Z;
  logic            N;
  logic            V;
  logic            C;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] imm;
  logic            pred_taken;

  // result side
  logic            out_valid;
  logic            out_ready;
  logic            taken;
  logic [XLEN-1:0] next_pc;
  logic [XLEN-1:0] target;
  logic            mispredict;
  logic            misaligned;
  logic            illegal;

  modport master (
    output in_valid, is_branch, funct3, Z, N, V, C, pc, imm, pred_taken, out_ready,
    input  in_ready, out_valid, taken, next_pc, target, mispredict, misaligned, illegal
  );

  modport slave (
    input  in_valid, is_branch, funct3, Z, N, V, C, pc, imm, pred_taken, out_ready,
    output in_ready, out_valid, taken, next_pc, target, mispredict, misaligned, illegal
  );
endinterface

// File: rtl/branch_resolve.sv
// Resolves RISC-V conditional branches and jumps from the ALU compare flags.
// It computes next PC and mispredict, and holds the result in a one-deep valid/ready register.
module branch_resolve #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  branch_resolve_if.slave   bus,
  output logic [CNT_W-1:0]  branch_cnt,
  output logic [CNT_W-1:0]  mispred_cnt
);

  typedef enum logic [2:0] {
    F3_BEQ  = 3'b000,
    F3_BNE  = 3'b001,
    F3_BLT  = 3'b100,
    F3_BGE  = 3'b101,
    F3_BLTU = 3'b110,
    F3_BGEU = 3'b111
  } funct3_e;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic            accept;
  logic            cond;
  logic            taken_c;
  logic            illegal_c;
  logic            mispredict_c;
  logic            misaligned_c;
  logic [XLEN-1:0] target_c;
  logic [XLEN-1:0] seq_pc_c;
  logic [XLEN-1:0] next_pc_c;

  logic            out_valid_q;
  logic            taken_q;
  logic            mispredict_q;
  logic            misaligned_q;
  logic            illegal_q;
  logic [XLEN-1:0] target_q;
  logic [XLEN-1:0] next_pc_q;

  // The slot is free when it is empty, or when its current result leaves this cycle.
  assign bus.in_ready = !out_valid_q || bus.out_ready;
  assign accept       = bus.in_valid && bus.in_ready;

  // Condition decode. Unconditional jumps ignore funct3. The reserved funct3 values
  // 010 and 011 resolve as not taken and flag illegal.
  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latch).
    cond      = 1'b0;
    illegal_c = 1'b0;
    if (!bus.is_branch) begin
      cond = 1'b1;
    end else begin
      unique case (bus.funct3)
        F3_BEQ:  cond = bus.Z;
        F3_BNE:  cond = !bus.Z;
        F3_BLT:  cond = bus.N ^ bus.V;
        F3_BGE:  cond = !(bus.N ^ bus.V);
        F3_BLTU: cond = !bus.C;
        F3_BGEU: cond = bus.C;
        default: illegal_c = 1'b1;
      endcase
    end
  end

  // Address arithmetic wraps modulo 2^XLEN.
  always_comb begin
    target_c     = bus.pc + bus.imm;
    seq_pc_c     = bus.pc + XLEN'(4);
    taken_c      = cond;
    next_pc_c    = taken_c ? target_c : seq_pc_c;
    mispredict_c = taken_c != bus.pred_taken;
    misaligned_c = taken_c && (target_c[1:0] != 2'b00);
  end

  // Result register. Reset discards any result still waiting and takes priority over the handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the data fields are reset too, because they are visible outputs with defined reset values.
      out_valid_q  <= 1'b0;
      taken_q      <= 1'b0;
      mispredict_q <= 1'b0;
      misaligned_q <= 1'b0;
      illegal_q    <= 1'b0;
      target_q     <= '0;
      next_pc_q    <= '0;
    end else if (accept) begin
      // NOTE: sequential state uses non-blocking assignments so every register updates from pre-edge values.
      out_valid_q  <= 1'b1;
      taken_q      <= taken_c;
      mispredict_q <= mispredict_c;
      misaligned_q <= misaligned_c;
      illegal_q    <= illegal_c;
      target_q     <= target_c;
      next_pc_q    <= next_pc_c;
    end else if (bus.out_ready) begin
      out_valid_q  <= 1'b0;
    end
  end

  // Performance counters advance on accept only and saturate instead of wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      branch_cnt  <= '0;
      mispred_cnt <= '0;
    end else if (accept) begin
      if (branch_cnt != CNT_MAX) begin
        branch_cnt <= branch_cnt + CNT_W'(1);
      end
      if (mispredict_c && (mispred_cnt != CNT_MAX)) begin
        mispred_cnt <= mispred_cnt + CNT_W'(1);
      end
    end
  end

  assign bus.out_valid  = out_valid_q;
  assign bus.taken      = taken_q;
  assign bus.mispredict = mispredict_q;
  assign bus.misaligned = misaligned_q;
  assign bus.illegal    = illegal_q;
  assign bus.target     = target_q;
  assign bus.next_pc    = next_pc_q;

endmodule

// File: tb/tb_branch_resolve.sv
// Directed bench for branch_resolve: a table of hand-computed vectors, plus sequences
// for backpressure, reset while a result is held, and counter saturation (CNT_W = 4).
module tb_branch_resolve;

  localparam int XLEN  = 32;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic [CNT_W-1:0] branch_cnt;
  logic [CNT_W-1:0] mispred_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_b    = 0;
  int exp_m    = 0;

  branch_resolve_if #(.XLEN(XLEN)) bif ();

  branch_resolve #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bif.slave),
    .branch_cnt  (branch_cnt),
    .mispred_cnt (mispred_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        is_branch;
    logic [2:0]  funct3;
    logic        z, n, v, c;
    logic [31:0] pc;
    logic [31:0] imm;
    logic        pred;
    logic        e_taken;
    logic [31:0] e_next;
    logic [31:0] e_target;
    logic        e_mis;
    logic        e_mal;
    logic        e_ill;
  } vec_t;

  vec_t vecs[14];

  function automatic vec_t mk(logic br, logic [2:0] f3, logic z, logic n, logic v, logic c,
                              logic [31:0] pc, logic [31:0] imm, logic pred, logic e_taken,
                              logic [31:0] e_next, logic [31:0] e_target,
                              logic e_mis, logic e_mal, logic e_ill);
    vec_t r;
    r.is_branch = br;  r.funct3 = f3;
    r.z = z; r.n = n; r.v = v; r.c = c;
    r.pc = pc; r.imm = imm; r.pred = pred;
    r.e_taken = e_taken; r.e_next = e_next; r.e_target = e_target;
    r.e_mis = e_mis; r.e_mal = e_mal; r.e_ill = e_ill;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Advance one clock. Outputs are read 1 ns after the edge, and inputs change at the same point.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input vec_t v);
    bif.in_valid   = 1'b1;
    bif.is_branch  = v.is_branch;
    bif.funct3     = v.funct3;
    bif.Z          = v.z;
    bif.N          = v.n;
    bif.V          = v.v;
    bif.C          = v.c;
    bif.pc         = v.pc;
    bif.imm        = v.imm;
    bif.pred_taken = v.pred;
  endtask

  task automatic check_result(input string tag, input vec_t v);
    check({tag, " out_valid"},  32'(bif.out_valid),  32'd1);
    check({tag, " taken"},      32'(bif.taken),      32'(v.e_taken));
    check({tag, " next_pc"},    bif.next_pc,         v.e_next);
    check({tag, " target"},     bif.target,          v.e_target);
    check({tag, " mispredict"}, 32'(bif.mispredict), 32'(v.e_mis));
    check({tag, " misaligned"}, 32'(bif.misaligned), 32'(v.e_mal));
    check({tag, " illegal"},    32'(bif.illegal),    32'(v.e_ill));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bif.in_valid = 1'b0;
    step();
    rst = 1'b0;
    exp_b = 0;
    exp_m = 0;
  endtask

  task automatic count_accept(input logic mis);
    exp_b = (exp_b == 15) ? 15 : exp_b + 1;
    if (mis) exp_m = (exp_m == 15) ? 15 : exp_m + 1;
  endtask

  initial begin
    //            br f3      z  n  v  c  pc            imm           pr tk next          target        mis mal ill
    vecs[0]  = mk(1, 3'b000, 1, 0, 0, 1, 32'h100,      32'h20,       0, 1, 32'h120,      32'h120,      1, 0, 0);
    vecs[1]  = mk(1, 3'b001, 1, 0, 0, 1, 32'h100,      32'h20,       0, 0, 32'h104,      32'h120,      0, 0, 0);
    vecs[2]  = mk(1, 3'b100, 0, 1, 0, 1, 32'h200,      32'h40,       0, 1, 32'h240,      32'h240,      1, 0, 0);
    vecs[3]  = mk(1, 3'b101, 0, 1, 0, 1, 32'h200,      32'h40,       0, 0, 32'h204,      32'h240,      0, 0, 0);
    vecs[4]  = mk(1, 3'b110, 0, 1, 0, 1, 32'h200,      32'h40,       1, 0, 32'h204,      32'h240,      1, 0, 0);
    vecs[5]  = mk(1, 3'b111, 0, 1, 0, 1, 32'h200,      32'h40,       1, 1, 32'h240,      32'h240,      0, 0, 0);
    vecs[6]  = mk(1, 3'b100, 0, 1, 1, 0, 32'h300,      32'h10,       0, 0, 32'h304,      32'h310,      0, 0, 0);
    vecs[7]  = mk(1, 3'b000, 0, 0, 0, 0, 32'hFFFFFFFC, 32'h8,        0, 0, 32'h0,        32'h4,        0, 0, 0);
    vecs[8]  = mk(0, 3'b011, 0, 0, 0, 0, 32'hFFFFFFFC, 32'h2,        1, 1, 32'hFFFFFFFE, 32'hFFFFFFFE, 0, 1, 0);
    vecs[9]  = mk(1, 3'b011, 1, 0, 0, 1, 32'h400,      32'h8,        1, 0, 32'h404,      32'h408,      1, 0, 1);
    vecs[10] = mk(1, 3'b010, 1, 0, 0, 1, 32'h400,      32'h8,        0, 0, 32'h404,      32'h408,      0, 0, 1);
    vecs[11] = mk(1, 3'b000, 0, 0, 0, 0, 32'h500,      32'h6,        0, 0, 32'h504,      32'h506,      0, 0, 0);
    vecs[12] = mk(1, 3'b001, 0, 0, 0, 0, 32'h500,      32'h6,        0, 1, 32'h506,      32'h506,      1, 1, 0);
    vecs[13] = mk(0, 3'b000, 0, 0, 0, 0, 32'h1000,     32'hFFFFFFF0, 0, 1, 32'hFF0,      32'hFF0,      1, 0, 0);

    rst = 1'b1;
    bif.out_ready = 1'b1;
    drive(vecs[0]);
    bif.in_valid = 1'b0;
    step();
    step();

    // Reset state (in_valid held low during reset)
    check("rst out_valid",   32'(bif.out_valid),  32'd0);
    check("rst taken",       32'(bif.taken),      32'd0);
    check("rst next_pc",     bif.next_pc,         32'd0);
    check("rst target",      bif.target,          32'd0);
    check("rst mispredict",  32'(bif.mispredict), 32'd0);
    check("rst misaligned",  32'(bif.misaligned), 32'd0);
    check("rst illegal",     32'(bif.illegal),    32'd0);
    check("rst branch_cnt",  32'(branch_cnt),     32'd0);
    check("rst mispred_cnt", 32'(mispred_cnt),    32'd0);
    rst = 1'b0;

    // Back-to-back table vectors with out_ready held high
    for (int i = 0; i < 14; i++) begin
      drive(vecs[i]);
      check($sformatf("vec%0d in_ready", i), 32'(bif.in_ready), 32'd1);
      step();
      count_accept(vecs[i].e_mis);
      check_result($sformatf("vec%0d", i), vecs[i]);
      check($sformatf("vec%0d branch_cnt", i),  32'(branch_cnt),  32'(exp_b));
      check($sformatf("vec%0d mispred_cnt", i), 32'(mispred_cnt), 32'(exp_m));
    end
    bif.in_valid = 1'b0;
    step();
    check("drain out_valid", 32'(bif.out_valid), 32'd0);

    // Backpressure: the result stays frozen, and inputs offered meanwhile are ignored
    do_reset();
    bif.out_ready = 1'b0;
    drive(vecs[0]);
    step();
    drive(vecs[1]);
    for (int k = 0; k < 5; k++) begin
      check($sformatf("bp%0d in_ready", k), 32'(bif.in_ready), 32'd0);
      check_result($sformatf("bp%0d", k), vecs[0]);
      check($sformatf("bp%0d branch_cnt", k), 32'(branch_cnt), 32'd1);
      step();
    end
    bif.out_ready = 1'b1;
    #1;
    check("bp release in_ready", 32'(bif.in_ready), 32'd1);
    step();
    check_result("bp swap", vecs[1]);
    check("bp swap branch_cnt", 32'(branch_cnt), 32'd2);
    bif.in_valid = 1'b0;
    step();
    check("bp drain out_valid", 32'(bif.out_valid), 32'd0);

    // Reset while a result is held and a new request is offered
    do_reset();
    drive(vecs[2]);
    step();
    check("mr pre out_valid", 32'(bif.out_valid), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mr out_valid",   32'(bif.out_valid), 32'd0);
    check("mr branch_cnt",  32'(branch_cnt),    32'd0);
    check("mr mispred_cnt", 32'(mispred_cnt),   32'd0);
    check("mr next_pc",     bif.next_pc,        32'd0);
    bif.in_valid = 1'b0;
    step();
    check("mr post out_valid",  32'(bif.out_valid), 32'd0);
    check("mr post branch_cnt", 32'(branch_cnt),    32'd0);

    // Saturation: 20 mispredicting jumps into 4-bit counters
    do_reset();
    drive(vecs[13]);
    for (int k = 0; k < 20; k++) begin
      step();
      count_accept(1'b1);
    end
    bif.in_valid = 1'b0;
    step();
    check("sat branch_cnt",  32'(branch_cnt),  32'(exp_b));
    check("sat mispred_cnt", 32'(mispred_cnt), 32'(exp_m));
    check("sat branch_cnt max", 32'(branch_cnt), 32'd15);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
